// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern path: FSM encoding and rate indices.
// The pattern sequencer imports this package as well.
package led_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSED = 2'b01,
        ST_STEP   = 2'b10
    } state_e;

    localparam logic [1:0] SPD_1X = 2'd0;
    localparam logic [1:0] SPD_2X = 2'd1;
    localparam logic [1:0] SPD_4X = 2'd2;
    localparam logic [1:0] SPD_8X = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-sample debounce counter,
// and a rising-edge detector that produces one press pulse per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int DB_W         = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            sync1_q, sync2_q;
    logic            lvl_q, lvl_d, lvl_prev_q;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The counter restarts on every sample that matches the current level,
    // so only an uninterrupted run of DEBOUNCE_CYC differing samples flips it.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            cnt_q      <= cnt_d;
        end
    end

    assign level = lvl_q;
    assign press = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/pattern_tick_ctrl.sv
// Step-pulse generator for the LED pattern sequencer: run/pause, single-step
// and a four-level rate select driven by two debounced buttons.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | tick counter running, step once per period
//   ST_PAUSED | tick counter frozen, no steps
//   ST_STEP   | single step issued from pause, returns to ST_PAUSED
module pattern_tick_ctrl
    import led_pkg::*;
#(
    parameter int BASE_DIV     = 25000000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = $clog2(BASE_DIV),
    parameter int DB_W         = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_speed,
    output logic       step,
    output logic       run,
    output logic [1:0] speed_sel
);

    state_e             state_q, state_d;
    logic [1:0]         speed_q, speed_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]   tick_last;
    logic               step_q, step_d;
    logic               pause_press, speed_press;
    logic               pause_lvl_unused, speed_lvl_unused;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DB_W(DB_W)) u_db_pause (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_pause),
        .level (pause_lvl_unused),
        .press (pause_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DB_W(DB_W)) u_db_speed (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_speed),
        .level (speed_lvl_unused),
        .press (speed_press)
    );

    assign tick_last = CNT_W'((BASE_DIV >> speed_q) - 1);

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        tick_d  = tick_q;
        step_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pause_press) begin
                    state_d = ST_PAUSED;
                end else if (speed_press) begin
                    speed_d = (speed_q == SPD_8X) ? SPD_1X : speed_q + 2'd1;
                    tick_d  = '0;
                end else if (tick_q == tick_last) begin
                    tick_d = '0;
                    step_d = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_PAUSED: begin
                // Resuming restarts the period so the first step is a full period away.
                if (pause_press) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end else if (speed_press) begin
                    state_d = ST_STEP;
                    step_d  = 1'b1;
                end
            end
            ST_STEP: state_d = ST_PAUSED;
            default: state_d = ST_PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            speed_q <= SPD_1X;
            tick_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
        end
    end

    assign step      = step_q;
    assign run       = (state_q == ST_RUN);
    assign speed_sel = speed_q;

endmodule

// File: tb/tb_pattern_tick_ctrl.sv
// Directed bench for pattern_tick_ctrl with BASE_DIV=16, DEBOUNCE_CYC=4.
module tb_pattern_tick_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_pause;
    logic       btn_speed;
    logic       step;
    logic       run;
    logic [1:0] speed_sel;

    int checks = 0;
    int errors = 0;

    pattern_tick_ctrl #(.BASE_DIV(16), .DEBOUNCE_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_speed (btn_speed),
        .step      (step),
        .run       (run),
        .speed_sel (speed_sel)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges until step is seen high (bounded by max).
    task automatic wait_step(input int max, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (step !== 1'b1 && n < max);
        if (step !== 1'b1) n = -1;
    endtask

    task automatic count_steps(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (step === 1'b1) n++;
        end
    endtask

    task automatic press_speed(input logic [1:0] old_spd, input logic [1:0] new_spd,
                               input int period, input string tag);
        int n;
        btn_speed = 1'b1;
        tick(6);
        chk({tag, "_before"}, speed_sel, old_spd);
        tick(1);
        chk({tag, "_after"}, speed_sel, new_spd);
        tick(3);
        btn_speed = 1'b0;
        chk({tag, "_once"}, speed_sel, new_spd);
        tick(8);
        wait_step(40, n);
        wait_step(40, n);
        chk({tag, "_period"}, n, period);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        btn_pause = 1'b0;
        btn_speed = 1'b0;
        tick(3);
        chk("rst_step", step, 0);
        chk("rst_run", run, 1);
        chk("rst_speed", speed_sel, 0);

        rst = 1'b0;
        wait_step(40, n);
        chk("first_step", n, 16);
        wait_step(40, n);
        chk("period_16", n, 16);

        press_speed(2'd0, 2'd1, 8, "spd1");
        press_speed(2'd1, 2'd2, 4, "spd2");
        press_speed(2'd2, 2'd3, 2, "spd3");
        press_speed(2'd3, 2'd0, 16, "spd0");

        btn_pause = 1'b1;
        tick(1);
        btn_pause = 1'b0;
        tick(8);
        chk("glitch1_run", run, 1);
        btn_pause = 1'b1;
        tick(3);
        btn_pause = 1'b0;
        tick(10);
        chk("glitch3_run", run, 1);
        chk("glitch_speed", speed_sel, 0);

        btn_pause = 1'b1;
        tick(6);
        btn_pause = 1'b0;
        chk("pause_pre", run, 1);
        tick(1);
        chk("pause_run", run, 0);
        count_steps(100, n);
        chk("pause_nostep", n, 0);

        btn_speed = 1'b1;
        tick(6);
        btn_speed = 1'b0;
        tick(1);
        chk("single_step_pulse", step, 1);
        count_steps(30, n);
        chk("single_step_once", n, 0);
        chk("single_step_run", run, 0);
        chk("single_step_speed", speed_sel, 0);

        btn_pause = 1'b1;
        tick(6);
        btn_pause = 1'b0;
        tick(1);
        chk("resume_run", run, 1);
        wait_step(40, n);
        chk("resume_first_step", n, 16);

        press_speed(2'd0, 2'd1, 8, "spd_again");

        btn_pause = 1'b1;
        btn_speed = 1'b1;
        tick(6);
        btn_pause = 1'b0;
        btn_speed = 1'b0;
        tick(1);
        chk("both_run", run, 0);
        chk("both_speed", speed_sel, 1);

        tick(5);
        rst = 1'b1;
        tick(1);
        chk("midrst_run", run, 1);
        chk("midrst_speed", speed_sel, 0);
        chk("midrst_step", step, 0);
        rst = 1'b0;
        wait_step(40, n);
        chk("midrst_first_step", n, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
